vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 111 +++++++++++
 tb/tb_vram_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Two-port arbiter sharing a single-port 128x64x2 VRAM between display scanout and a CPU/draw engine.
// Scanout has priority; a saturating counter guarantees the CPU a slot after STARVE_LIMIT scan grants.
module vram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic       cpu_xor,
  input  logic [6:0] cpu_hpos,
  input  logic [5:0] cpu_vpos,
  input  logic [1:0] cpu_pixeli,
  output logic       cpu_ack,
  output logic [1:0] cpu_pixelo,
  output logic       collision,
  input  logic       collision_clr,
  input  logic       scan_req,
  input  logic [6:0] scan_hpos,
  input  logic [5:0] scan_vpos,
  output logic       scan_ack,
  output logic [1:0] scan_pixelo,
  output logic [6:0] vram_hpos,
  output logic [5:0] vram_vpos,
  output logic [1:0] vram_pixeli,
  input  logic [1:0] vram_pixelo,
  output logic       vram_we
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE, SCAN_ADDR, SCAN_DATA, CPU_ADDR, CPU_DATA, CPU_WR
  } state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic [6:0]    lat_hpos;
  logic [5:0]    lat_vpos;
  logic [1:0]    lat_data;
  logic          lat_xor;

  logic xor_phase;
  logic xor_hit;
  logic cpu_grant;

  assign cpu_grant = cpu_req && (!scan_req || starve_cnt == LIMIT);
  assign xor_phase = (state == CPU_DATA) && lat_xor;
  assign xor_hit   = xor_phase && |(vram_pixelo & lat_data);

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_hpos   <= '0;
      lat_vpos   <= '0;
      lat_data   <= '0;
      lat_xor    <= 1'b0;
      collision  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_grant) begin
            state      <= (cpu_we && !cpu_xor) ? CPU_WR : CPU_ADDR;
            lat_hpos   <= cpu_hpos;
            lat_vpos   <= cpu_vpos;
            lat_data   <= cpu_pixeli;
            lat_xor    <= cpu_we && cpu_xor;
            starve_cnt <= '0;
          end else if (scan_req) begin
            state    <= SCAN_ADDR;
            lat_hpos <= scan_hpos;
            lat_vpos <= scan_vpos;
            lat_data <= '0;
            lat_xor  <= 1'b0;
            // A scan grant with cpu_req pending implies starve_cnt < LIMIT, so this saturates.
            starve_cnt <= cpu_req ? starve_cnt + 1'b1 : '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        SCAN_ADDR: state <= SCAN_DATA;
        SCAN_DATA: state <= IDLE;
        CPU_ADDR:  state <= CPU_DATA;
        CPU_DATA:  state <= IDLE;
        CPU_WR:    state <= IDLE;
        default:   state <= IDLE;
      endcase

      if (xor_hit)
        collision <= 1'b1;
      else if (collision_clr)
        collision <= 1'b0;
    end
  end

  // Strobes are gated by rst_n so a reset landing mid-access suppresses the write and the ack.
  assign scan_ack    = rst_n && (state == SCAN_DATA);
  assign cpu_ack     = rst_n && (state == CPU_DATA || state == CPU_WR);
  assign vram_we     = rst_n && (state == CPU_WR || xor_phase);
  assign scan_pixelo = scan_ack ? vram_pixelo : 2'b00;
  assign cpu_pixelo  = (rst_n && state == CPU_DATA) ? vram_pixelo : 2'b00;

  assign vram_hpos   = (state == IDLE) ? 7'd0 : lat_hpos;
  assign vram_vpos   = (state == IDLE) ? 6'd0 : lat_vpos;
  assign vram_pixeli = (state == IDLE) ? 2'b00 :
                       xor_phase       ? (vram_pixelo ^ lat_data) : lat_data;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered-read VRAM model and hand-computed expectations.
module tb_vram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we, cpu_xor;
  logic [6:0] cpu_hpos;
  logic [5:0] cpu_vpos;
  logic [1:0] cpu_pixeli;
  logic       cpu_ack;
  logic [1:0] cpu_pixelo;
  logic       collision, collision_clr;
  logic       scan_req;
  logic [6:0] scan_hpos;
  logic [5:0] scan_vpos;
  logic       scan_ack;
  logic [1:0] scan_pixelo;
  logic [6:0] vram_hpos;
  logic [5:0] vram_vpos;
  logic [1:0] vram_pixeli;
  logic [1:0] vram_pixelo;
  logic       vram_we;

  always #5 clk = ~clk;

  vram_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_xor(cpu_xor),
    .cpu_hpos(cpu_hpos), .cpu_vpos(cpu_vpos), .cpu_pixeli(cpu_pixeli),
    .cpu_ack(cpu_ack), .cpu_pixelo(cpu_pixelo),
    .collision(collision), .collision_clr(collision_clr),
    .scan_req(scan_req), .scan_hpos(scan_hpos), .scan_vpos(scan_vpos),
    .scan_ack(scan_ack), .scan_pixelo(scan_pixelo),
    .vram_hpos(vram_hpos), .vram_vpos(vram_vpos), .vram_pixeli(vram_pixeli),
    .vram_pixelo(vram_pixelo), .vram_we(vram_we)
  );

  // VRAM model: read data appears the cycle after the address; a preload port seeds contents.
  logic [1:0] mem [0:127][0:63];
  logic       pre_we;
  logic [6:0] pre_h;
  logic [5:0] pre_v;
  logic [1:0] pre_d;

  always @(posedge clk) begin
    vram_pixelo <= mem[vram_hpos][vram_vpos];
    if (pre_we)
      mem[pre_h][pre_v] <= pre_d;
    else if (vram_we)
      mem[vram_hpos][vram_vpos] <= vram_pixeli;
  end

  int n_scan_ack = 0;
  int n_cpu_ack  = 0;
  int n_overlap  = 0;
  int n_we       = 0;

  always @(negedge clk) begin
    if (scan_ack) n_scan_ack++;
    if (cpu_ack) n_cpu_ack++;
    if (scan_ack && cpu_ack) n_overlap++;
    if (vram_we) n_we++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [6:0] h, input logic [5:0] v, input logic [1:0] d);
    pre_h = h; pre_v = v; pre_d = d; pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  task automatic cpu_set(input logic we, input logic x, input logic [6:0] h,
                         input logic [5:0] v, input logic [1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_xor = x;
    cpu_hpos = h; cpu_vpos = v; cpu_pixeli = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int snap_ack, snap_we, scan_at, cpu_at, scans_before;
    logic [1:0] got_pix;
    logic got_we;

    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_xor = 0; cpu_hpos = 0; cpu_vpos = 0; cpu_pixeli = 0;
    scan_req = 0; scan_hpos = 0; scan_vpos = 0; collision_clr = 0;
    pre_we = 0; pre_h = 0; pre_v = 0; pre_d = 0;
    step(); step();

    check("rst_we", vram_we, 0);
    check("rst_scan_ack", scan_ack, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_collision", collision, 0);
    check("rst_hpos", vram_hpos, 0);
    check("rst_pixeli", vram_pixeli, 0);

    rst_n = 1'b1;
    step();
    check("idle_we", vram_we, 0);
    check("idle_vpos", vram_vpos, 0);

    preload(5, 3, 2);
    preload(10, 4, 3);
    preload(20, 5, 1);
    preload(1, 1, 1);
    preload(2, 2, 2);
    preload(7, 7, 1);

    // Scan-only read of (5,3)
    snap_we = n_we;
    scan_req = 1; scan_hpos = 5; scan_vpos = 3;
    step();
    check("scan_addr_hpos", vram_hpos, 5);
    check("scan_addr_vpos", vram_vpos, 3);
    check("scan_addr_ack", scan_ack, 0);
    scan_hpos = 9;
    step();
    check("scan_data_ack", scan_ack, 1);
    check("scan_data_pix", scan_pixelo, 2);
    check("scan_data_hold", vram_hpos, 5);
    scan_req = 0;
    step();
    check("scan_done_ack", scan_ack, 0);
    check("scan_done_hpos", vram_hpos, 0);
    check("scan_no_write", n_we - snap_we, 0);

    // Colliding XOR at (10,4): 3 ^ 3
    cpu_set(1, 1, 10, 4, 3);
    step();
    check("xor_addr_we", vram_we, 0);
    check("xor_addr_hpos", vram_hpos, 10);
    step();
    check("xor_data_ack", cpu_ack, 1);
    check("xor_data_pixo", cpu_pixelo, 3);
    check("xor_data_we", vram_we, 1);
    check("xor_data_pixi", vram_pixeli, 0);
    cpu_req = 0;
    step();
    check("xor_mem", mem[10][4], 0);
    check("xor_collision_set", collision, 1);
    collision_clr = 1;
    step();
    collision_clr = 0;
    check("collision_clr", collision, 0);

    // Non-colliding XOR at (20,5): 1 ^ 2
    cpu_set(1, 1, 20, 5, 2);
    step(); step();
    check("xor2_pixo", cpu_pixelo, 1);
    check("xor2_pixi", vram_pixeli, 3);
    cpu_req = 0;
    step();
    check("xor2_mem", mem[20][5], 3);
    check("xor2_no_collision", collision, 0);

    // Simultaneous scan (1,1) and cpu read (2,2)
    scan_at = -1; cpu_at = -1; got_pix = 0;
    scan_req = 1; scan_hpos = 1; scan_vpos = 1;
    cpu_set(0, 0, 2, 2, 0);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (scan_ack) begin scan_at = c; scan_req = 0; end
      if (cpu_ack) begin cpu_at = c; got_pix = cpu_pixelo; cpu_req = 0; break; end
    end
    check("simul_scan_cycle", scan_at, 2);
    check("simul_cpu_cycle", cpu_at, 5);
    check("simul_cpu_pix", got_pix, 2);
    step();

    // Starvation: scan held, cpu plain write to (3,3) pending
    snap_ack = n_scan_ack; snap_we = n_we;
    scans_before = -1; got_we = 0;
    scan_req = 1; scan_hpos = 0; scan_vpos = 0;
    cpu_set(1, 0, 3, 3, 1);
    for (int c = 0; c < 60; c++) begin
      step();
      if (cpu_ack) begin
        scans_before = n_scan_ack - snap_ack;
        got_we = vram_we;
        cpu_req = 0; scan_req = 0;
        break;
      end
    end
    step(); step();
    check("starve_scan_acks", scans_before, 8);
    check("starve_cpu_we", got_we, 1);
    check("starve_one_write", n_we - snap_we, 1);
    check("starve_mem", mem[3][3], 1);

    // Reset asserted during CPU_WR to (7,7)
    snap_ack = n_cpu_ack;
    cpu_set(1, 0, 7, 7, 3);
    step();
    check("rstw_pre_we", vram_we, 1);
    rst_n = 0;
    #1;
    check("rstw_we", vram_we, 0);
    check("rstw_ack", cpu_ack, 0);
    step();
    rst_n = 1; cpu_req = 0;
    check("rstw_idle_hpos", vram_hpos, 0);
    step();
    check("rstw_mem", mem[7][7], 1);
    check("rstw_no_ack", n_cpu_ack - snap_ack, 0);

    // Back-to-back plain writes: (0,0) then (127,63)
    cpu_set(1, 0, 0, 0, 2);
    step();
    check("b2b1_ack", cpu_ack, 1);
    check("b2b1_we", vram_we, 1);
    check("b2b1_pos", {vram_hpos, vram_vpos}, {7'd0, 6'd0});
    check("b2b1_pixi", vram_pixeli, 2);
    cpu_hpos = 127; cpu_vpos = 63; cpu_pixeli = 1;
    step();
    check("b2b_gap_ack", cpu_ack, 0);
    check("b2b_gap_we", vram_we, 0);
    step();
    check("b2b2_ack", cpu_ack, 1);
    check("b2b2_pos", {vram_hpos, vram_vpos}, {7'd127, 6'd63});
    check("b2b2_pixi", vram_pixeli, 1);
    cpu_req = 0;
    step();
    check("b2b_mem0", mem[0][0], 2);
    check("b2b_mem1", mem[127][63], 1);

    check("ack_overlap", n_overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
